// File: rtl/vfifo_pkg.sv
// Shared types and helpers for the multi-channel virtual FIFO.
// Per-channel status bundle, count sizing and a constant-safe clog2.
package vfifo_pkg;

  localparam int CH_ADDR_WIDTH_DEF = 6;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // A channel holds 0..depth words, so its count needs one bit more than a pointer.
  function automatic int count_width(input int ch_addr_width);
    return ch_addr_width + 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic overflow;
    logic underflow;
  } ch_status_t;

endpackage

// File: rtl/vfifo_sdp_ram.sv
// Simple dual-port RAM, one clock: one write port, one read port with a
// registered output that holds its value when no read is issued.
module vfifo_sdp_ram
  import vfifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  localparam int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset so it maps onto block RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/vfifo_multi_channel_sync.sv
// N-channel synchronous FIFO sharing one statically partitioned RAM.
// Each channel owns pointers, a fill count, flags, sticky errors and a flush.
module vfifo_multi_channel_sync
  import vfifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int CH_ADDR_WIDTH = CH_ADDR_WIDTH_DEF,
  parameter int CH_WIDTH      = 2,
  parameter int AF_LEVEL      = 2**CH_ADDR_WIDTH - 4,
  localparam int NR_CH        = 2**CH_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [CH_WIDTH-1:0]   wr_ch,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  rd,
  input  logic [CH_WIDTH-1:0]   rd_ch,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  input  logic [NR_CH-1:0]      flush,
  output logic [NR_CH-1:0]      empty,
  output logic [NR_CH-1:0]      full,
  output logic [NR_CH-1:0]      almost_full,
  output logic [NR_CH-1:0]      overflow,
  output logic [NR_CH-1:0]      underflow
);

  localparam int DEPTH     = 2**CH_ADDR_WIDTH;
  localparam int CNT_W     = count_width(CH_ADDR_WIDTH);
  localparam int RAM_DEPTH = NR_CH * DEPTH;

  logic [CH_ADDR_WIDTH-1:0] wr_ptr_arr [NR_CH];
  logic [CH_ADDR_WIDTH-1:0] rd_ptr_arr [NR_CH];
  ch_status_t               status     [NR_CH];

  logic wr_ok;
  logic wr_drop;
  logic rd_ok;
  logic rd_drop;

  // Acceptance uses pre-edge flags, so a same-cycle write cannot rescue a read
  // of an empty channel and a same-cycle read cannot make room for a write.
  always_comb begin
    // NOTE: every output gets a default before the ifs, so no path leaves one unassigned (no latch).
    wr_ok   = 1'b0;
    wr_drop = 1'b0;
    rd_ok   = 1'b0;
    rd_drop = 1'b0;
    if (wr && !flush[wr_ch]) begin
      if (full[wr_ch]) wr_drop = 1'b1;
      else             wr_ok   = 1'b1;
    end
    if (rd && !flush[rd_ch]) begin
      if (empty[rd_ch]) rd_drop = 1'b1;
      else              rd_ok   = 1'b1;
    end
  end

  for (genvar i = 0; i < NR_CH; i++) begin : g_ch
    logic [CH_ADDR_WIDTH-1:0] wr_ptr;
    logic [CH_ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]         count;
    logic                     ovf;
    logic                     unf;
    logic                     wr_hit;
    logic                     rd_hit;

    assign wr_hit = wr_ok && (wr_ch == CH_WIDTH'(i));
    assign rd_hit = rd_ok && (rd_ch == CH_WIDTH'(i));

    // NOTE: state registers use non-blocking assignments so all channels update from the same pre-edge values.
    always_ff @(posedge clk) begin
      if (rst || flush[i]) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
        unf    <= 1'b0;
      end else begin
        if (wr_hit) wr_ptr <= wr_ptr + CH_ADDR_WIDTH'(1);
        if (rd_hit) rd_ptr <= rd_ptr + CH_ADDR_WIDTH'(1);
        if (wr_hit && !rd_hit) begin
          count <= count + CNT_W'(1);
        end else if (rd_hit && !wr_hit) begin
          count <= count - CNT_W'(1);
        end
        if (wr_drop && (wr_ch == CH_WIDTH'(i))) ovf <= 1'b1;
        if (rd_drop && (rd_ch == CH_WIDTH'(i))) unf <= 1'b1;
      end
    end

    assign status[i] = '{
      empty:       (count == '0),
      full:        (count == CNT_W'(DEPTH)),
      almost_full: (count >= CNT_W'(AF_LEVEL)),
      overflow:    ovf,
      underflow:   unf
    };

    assign empty[i]       = status[i].empty;
    assign full[i]        = status[i].full;
    assign almost_full[i] = status[i].almost_full;
    assign overflow[i]    = status[i].overflow;
    assign underflow[i]   = status[i].underflow;
    assign wr_ptr_arr[i]  = wr_ptr;
    assign rd_ptr_arr[i]  = rd_ptr;
  end

  // Channel index forms the upper address bits, giving each channel its own region.
  vfifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RAM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr ({wr_ch, wr_ptr_arr[wr_ch]}),
    .wdata (d),
    .re    (rd_ok),
    .raddr ({rd_ch, rd_ptr_arr[rd_ch]}),
    .rdata (q)
  );

  always_ff @(posedge clk) begin
    if (rst) q_valid <= 1'b0;
    else     q_valid <= rd_ok;
  end

endmodule

// File: tb/tb_vfifo_multi_channel_sync.sv
// Directed bench for vfifo_multi_channel_sync: a per-channel FIFO model predicts
// read data into a scoreboard and flag values, compared after every clock edge.
module tb_vfifo_multi_channel_sync;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int CW    = 2;
  localparam int NR    = 4;
  localparam int DEPTH = 64;
  localparam int AF    = 60;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic [CW-1:0] wr_ch;
  logic [DW-1:0] d;
  logic          rd;
  logic [CW-1:0] rd_ch;
  logic [DW-1:0] q;
  logic          q_valid;
  logic [NR-1:0] flush;
  logic [NR-1:0] empty;
  logic [NR-1:0] full;
  logic [NR-1:0] almost_full;
  logic [NR-1:0] overflow;
  logic [NR-1:0] underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] mdata [NR][DEPTH];
  int            mwp  [NR];
  int            mrp  [NR];
  int            mcnt [NR];
  logic [NR-1:0] movf;
  logic [NR-1:0] munf;
  logic          exp_qv;

  vfifo_multi_channel_sync #(
    .DATA_WIDTH    (DW),
    .CH_ADDR_WIDTH (AW),
    .CH_WIDTH      (CW),
    .AF_LEVEL      (AF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .wr_ch       (wr_ch),
    .d           (d),
    .rd          (rd),
    .rd_ch       (rd_ch),
    .q           (q),
    .q_valid     (q_valid),
    .flush       (flush),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mwp[i]  = 0;
      mrp[i]  = 0;
      mcnt[i] = 0;
    end
    movf   = '0;
    munf   = '0;
    exp_qv = 1'b0;
    sb.delete();
  endtask

  task automatic compare_outputs();
    logic [NR-1:0] e_empty, e_full, e_af;
    logic [DW-1:0] exp_q;
    check("q_valid", q_valid, exp_qv);
    if (q_valid === 1'b1) begin
      check("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_q = sb.pop_front();
        check("q_data", q, exp_q);
      end
    end
    for (int i = 0; i < NR; i++) begin
      e_empty[i] = (mcnt[i] == 0);
      e_full[i]  = (mcnt[i] == DEPTH);
      e_af[i]    = (mcnt[i] >= AF);
    end
    check("empty", empty, e_empty);
    check("full", full, e_full);
    check("almost_full", almost_full, e_af);
    check("overflow", overflow, movf);
    check("underflow", underflow, munf);
  endtask

  // One clock with the given requests; the model is advanced from pre-edge state.
  task automatic cyc(input bit w, input int wc, input logic [DW-1:0] dd,
                     input bit r, input int rc, input logic [NR-1:0] fl);
    bit w_ok, w_rej, r_ok, r_rej;
    wr    = w;
    wr_ch = CW'(wc);
    d     = dd;
    rd    = r;
    rd_ch = CW'(rc);
    flush = fl;
    w_ok  = w && !fl[wc] && (mcnt[wc] != DEPTH);
    w_rej = w && !fl[wc] && (mcnt[wc] == DEPTH);
    r_ok  = r && !fl[rc] && (mcnt[rc] != 0);
    r_rej = r && !fl[rc] && (mcnt[rc] == 0);
    if (r_ok) begin
      sb.push_back(mdata[rc][mrp[rc]]);
      mrp[rc] = (mrp[rc] + 1) % DEPTH;
      mcnt[rc]--;
    end
    if (w_ok) begin
      mdata[wc][mwp[wc]] = dd;
      mwp[wc] = (mwp[wc] + 1) % DEPTH;
      mcnt[wc]++;
    end
    if (w_rej) movf[wc] = 1'b1;
    if (r_rej) munf[rc] = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (fl[i]) begin
        mwp[i]  = 0;
        mrp[i]  = 0;
        mcnt[i] = 0;
        movf[i] = 1'b0;
        munf[i] = 1'b0;
      end
    end
    exp_qv = r_ok;
    @(posedge clk);
    #1;
    wr    = 1'b0;
    rd    = 1'b0;
    flush = '0;
    compare_outputs();
  endtask

  task automatic wr_only(input int ch, input logic [DW-1:0] dd);
    cyc(1'b1, ch, dd, 1'b0, 0, '0);
  endtask

  task automatic rd_only(input int ch);
    cyc(1'b0, 0, '0, 1'b1, ch, '0);
  endtask

  initial begin
    rst   = 1'b1;
    wr    = 1'b0;
    rd    = 1'b0;
    wr_ch = '0;
    rd_ch = '0;
    d     = '0;
    flush = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("reset_q", q, 0);
    check("reset_q_valid", q_valid, 0);
    check("reset_empty", empty, 4'hF);
    check("reset_full", full, 0);
    check("reset_af", almost_full, 0);
    check("reset_ovf", overflow, 0);
    check("reset_unf", underflow, 0);

    // Basic in-order traffic on channel 1
    for (int i = 0; i < 4; i++) wr_only(1, 32'hA0 + DW'(i));
    for (int i = 0; i < 4; i++) rd_only(1);
    check("ch1_empty_after_drain", empty[1], 1);

    // Interleaved channels
    wr_only(0, 32'h11);
    wr_only(2, 32'h22);
    wr_only(0, 32'h33);
    rd_only(2);
    rd_only(0);
    rd_only(0);
    check("all_empty_after_interleave", empty, 4'hF);

    // Offset ch3 pointers, then fill to depth, overflow, drain, refill across the wrap
    for (int i = 0; i < 20; i++) wr_only(3, 32'h200 + DW'(i));
    for (int i = 0; i < 20; i++) rd_only(3);
    for (int i = 0; i < DEPTH; i++) begin
      wr_only(3, 32'h300 + DW'(i));
      if (i == AF - 2) check("ch3_af_before_60", almost_full[3], 0);
      if (i == AF - 1) check("ch3_af_at_60", almost_full[3], 1);
      if (i == DEPTH - 2) check("ch3_not_full_at_63", full[3], 0);
    end
    check("ch3_full_at_64", full[3], 1);
    wr_only(3, 32'hDEAD);
    check("ch3_overflow", overflow[3], 1);
    check("ch3_still_full", full[3], 1);
    for (int i = 0; i < DEPTH; i++) rd_only(3);
    check("ch3_empty_after_drain", empty[3], 1);
    for (int i = 0; i < DEPTH; i++) wr_only(3, 32'h3100 + DW'(i));
    for (int i = 0; i < DEPTH; i++) rd_only(3);

    // Underflow, then write+read to an empty channel in the same cycle
    rd_only(0);
    check("ch0_underflow", underflow[0], 1);
    cyc(1'b1, 0, 32'h55, 1'b1, 0, '0);
    check("ch0_underflow_sticky", underflow[0], 1);
    check("ch0_not_empty", empty[0], 0);
    rd_only(0);
    check("ch0_empty_again", empty[0], 1);

    // Simultaneous write and read at count 5
    for (int i = 0; i < 5; i++) wr_only(1, 32'h500 + DW'(i));
    cyc(1'b1, 1, 32'h5AA, 1'b1, 1, '0);
    for (int i = 0; i < 4; i++) rd_only(1);
    check("ch1_one_left", empty[1], 0);
    rd_only(1);
    check("ch1_empty_after_5", empty[1], 1);

    // Flush ch2 holding 10 words with overflow set, while writing and reading it
    for (int i = 0; i < DEPTH; i++) wr_only(2, 32'h600 + DW'(i));
    wr_only(2, 32'hBEEF);
    for (int i = 0; i < DEPTH - 10; i++) rd_only(2);
    check("ch2_overflow_before_flush", overflow[2], 1);
    cyc(1'b1, 2, 32'hBAD, 1'b1, 2, 4'b0100);
    check("ch2_empty_after_flush", empty[2], 1);
    check("ch2_overflow_cleared", overflow[2], 0);
    wr_only(2, 32'h777);
    rd_only(2);

    // Reset in the middle of traffic
    for (int i = 0; i < 3; i++) wr_only(0, 32'h900 + DW'(i));
    wr_only(1, 32'h910);
    rst   = 1'b1;
    wr    = 1'b1;
    wr_ch = 2'd1;
    d     = 32'h999;
    rd    = 1'b1;
    rd_ch = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
    model_reset();
    check("midrst_q", q, 0);
    check("midrst_q_valid", q_valid, 0);
    check("midrst_empty", empty, 4'hF);
    check("midrst_ovf", overflow, 0);
    check("midrst_unf", underflow, 0);
    rd_only(0);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vfifo_multi_channel_sync.md
Name: vfifo_multi_channel_sync

Overview:
- N-channel synchronous FIFO. All channels share one simple dual-port RAM that is statically partitioned into NR_CH equal regions.
- Each channel has its own read/write pointers, fill count, flags, sticky error bits and flush.
- Used where several low-rate streams would each otherwise consume a separate RAM block, e.g. per-queue buffering ahead of an arbiter.

Parameters:
- DATA_WIDTH, 32, word width.
- CH_ADDR_WIDTH, 6, log2 of per-channel depth; depth = 2^CH_ADDR_WIDTH.
- CH_WIDTH, 2, log2 of channel count; NR_CH = 2^CH_WIDTH.
- AF_LEVEL, 2^CH_ADDR_WIDTH-4, fill count at or above which almost_full asserts; range 1..depth.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- wr  in  1  write request.
- wr_ch  in  CH_WIDTH  target channel of the write.
- d  in  DATA_WIDTH  write data.
- rd  in  1  read request.
- rd_ch  in  CH_WIDTH  source channel of the read.
- q  out  DATA_WIDTH  read data, registered.
- q_valid  out  1  q holds data from the accepted read of the previous cycle.
- flush  in  NR_CH  per-channel flush, one bit per channel.
- empty  out  NR_CH  per-channel empty.
- full  out  NR_CH  per-channel full.
- almost_full  out  NR_CH  per-channel count >= AF_LEVEL.
- overflow  out  NR_CH  sticky: a write to a full channel was rejected.
- underflow  out  NR_CH  sticky: a read from an empty channel was rejected.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All pointers and counts = 0.
  - empty = all 1s; full, almost_full, overflow, underflow = 0.
  - q = 0, q_valid = 0.
  - RAM contents are not cleared.
- Per-channel state:
  - wr_ptr and rd_ptr are CH_ADDR_WIDTH bits each and wrap modulo depth.
  - count is CH_ADDR_WIDTH+1 bits, range 0..depth.
- Flags are combinational from count: empty = (count==0), full = (count==depth), almost_full = (count>=AF_LEVEL).
- RAM physical address = {channel, ptr}. Total RAM words = NR_CH * depth.
- Write acceptance:
  - Accepted iff wr=1, full[wr_ch]=0 and flush[wr_ch]=0.
  - On accept: RAM[{wr_ch, wr_ptr}] <= d; wr_ptr+1; count+1.
  - wr=1 with full[wr_ch]=1: write dropped, no state change, overflow[wr_ch] <= 1.
- Read acceptance:
  - Accepted iff rd=1, empty[rd_ch]=0 and flush[rd_ch]=0.
  - On accept: q <= RAM[{rd_ch, rd_ptr}]; rd_ptr+1; count-1.
  - Read latency is 1 cycle: q and q_valid update at the same edge the read is accepted and are visible the following cycle.
  - rd=1 with empty[rd_ch]=1: read dropped, underflow[rd_ch] <= 1, q_valid <= 0.
  - No accepted read: q holds its value, q_valid <= 0.
- Flags are evaluated on pre-edge state:
  - A write to an empty channel does not allow a same-cycle read of that channel; the read is rejected and underflow is set.
  - A read from a full channel does not allow a same-cycle write to that channel; the write is rejected and overflow is set.
- Simultaneous accepted write and read on the same channel: both pointers advance, count unchanged.
- Accepted write and read on different channels: fully independent.
- No RAM read/write address collision is possible:
  - Pointers are equal only when the channel is empty or full.
  - In those states the conflicting access is rejected, so no read-during-write rule is needed.
- Flush:
  - flush[i]=1: channel i wr_ptr, rd_ptr and count = 0; overflow[i] = 0; underflow[i] = 0.
  - Flush overrides any wr/rd addressed to channel i in that cycle; those requests are dropped without setting error bits.
  - q_valid = 0 if the read targeted a flushed channel.
  - Other channels are unaffected.
- rst has priority over flush and all requests.
- Sticky bits clear only on rst or flush of that channel.

Decomposition:
- Package vfifo_pkg: clog2 function, count-width constant (CH_ADDR_WIDTH+1), per-channel status typedef (empty/full/almost_full/overflow/underflow).
- Sub-module vfifo_sdp_ram:
  - Simple dual-port, one clock.
  - Write port: we, waddr, wdata. Read port: re, raddr, registered rdata.
  - Width/depth parameterised; no reset on storage.
- Top level holds the per-channel pointer/count generate loop, acceptance logic and the q_valid register.

Test Plan:
- Reset, then write 0xA0..0xA3 to ch 1, read ch 1 x4 -> q = 0xA0, 0xA1, 0xA2, 0xA3 one cycle after each rd, q_valid=1 each; empty[1]=1 at end.
- Interleave: write ch0=0x11, ch2=0x22, ch0=0x33; read ch2, ch0, ch0 -> q = 0x22, 0x11, 0x33; other channels stay empty.
- Fill ch3 with 64 words (default depth):
  - almost_full[3] asserts after the 60th write; full[3] after the 64th.
  - 65th write -> overflow[3]=1, count stays 64.
  - Drain -> words 0..63 in order; pointer wraps cleanly on a second fill.
- Read empty ch 0 -> underflow[0]=1, q_valid=0. Write ch0 with rd ch0 in the same cycle -> read rejected, underflow stays 1, count[0]=1.
- Channel at count 5, simultaneous accepted wr and rd -> count stays 5, q = oldest word.
- flush[2] with 10 words in ch2 and overflow[2]=1, while wr to ch2 -> empty[2]=1, overflow[2]=0, write dropped.
- rst asserted mid-traffic -> all empty, q=0, q_valid=0 the following cycle.
